// File: rtl/mux2_1_feeder_pkg.sv
// mux2_1_feeder_pkg: shared defaults, channel type and count-width helper for the feeder.
package mux2_1_feeder_pkg;
  localparam int DEFAULT_WIDTH = 4;
  localparam int DEFAULT_DEPTH = 4;
  typedef enum logic {CH0, CH1} ch_t;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/mux2_1_feeder_if.sv
// mux2_1_feeder_if: producer channels plus the mux2_1 drive/handshake bundle.
interface mux2_1_feeder_if #(parameter int WIDTH = mux2_1_feeder_pkg::DEFAULT_WIDTH);
  logic             s0_valid, s0_ready;
  logic [WIDTH-1:0] s0_data;
  logic             s1_valid, s1_ready;
  logic [WIDTH-1:0] s1_data;
  logic [WIDTH-1:0] in0, in1;
  logic             sel, mux_valid, mux_ready;
  modport master (
    input  s0_valid, s0_data, s1_valid, s1_data, mux_ready,
    output s0_ready, s1_ready, in0, in1, sel, mux_valid
  );
  modport slave (
    output s0_valid, s0_data, s1_valid, s1_data, mux_ready,
    input  s0_ready, s1_ready, in0, in1, sel, mux_valid
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer whose head reads 0 when empty.
module sync_fifo
  import mux2_1_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          data,
  output logic [WIDTH-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full    = count == FULL_CNT;
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + AW'(do_push);
      rp    <= rp + AW'(do_pop);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // Storage needs no reset: the head is masked whenever the count is zero.
  always_ff @(posedge clk) if (do_push) mem[wp] <= data;
endmodule

// File: rtl/mux2_1_feeder.sv
// mux2_1_feeder: two buffered channels arbitrated round-robin onto mux2_1 in0/in1/sel.
module mux2_1_feeder
  import mux2_1_feeder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input logic clk,
  input logic rst_n,
  mux2_1_feeder_if.master bus
);
  localparam int CW = cnt_w(DEPTH);
  ch_t sel_q, sel_d;
  logic [WIDTH-1:0] head0, head1;
  logic [CW-1:0] cnt0, cnt1;
  logic full0, full1, empty0, empty1, push0, push1, pop, mux_valid, other_busy;
  assign push0 = bus.s0_valid && !full0;
  assign push1 = bus.s1_valid && !full1;
  assign mux_valid = sel_q == CH0 ? !empty0 : !empty1;
  assign pop = mux_valid && bus.mux_ready;
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f0 (
    .clk(clk), .rst_n(rst_n), .push(push0), .pop(pop && sel_q == CH0), .data(bus.s0_data),
    .head(head0), .full(full0), .empty(empty0), .count(cnt0)
  );
  sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_f1 (
    .clk(clk), .rst_n(rst_n), .push(push1), .pop(pop && sel_q == CH1), .data(bus.s1_data),
    .head(head1), .full(full1), .empty(empty1), .count(cnt1)
  );
  // The other channel counts as ready if it holds a word or gains one at this edge.
  always_comb begin
    other_busy = sel_q == CH0 ? (|cnt1 || push1) : (|cnt0 || push0);
    sel_d = ((mux_valid && !bus.mux_ready) || !other_busy) ? sel_q : (sel_q == CH0 ? CH1 : CH0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= CH0;
    else sel_q <= sel_d;
  end
  assign bus.s0_ready  = !full0;
  assign bus.s1_ready  = !full1;
  assign bus.in0       = head0;
  assign bus.in1       = head1;
  assign bus.sel       = sel_q;
  assign bus.mux_valid = mux_valid;
endmodule
